// File: rtl/wb_snoop_tracer_if.sv
// -----------------------------------------------------------------------------
// wb_snoop_tracer_if
// Bundles the two Wishbone views seen by the trace buffer:
//   snoop_*  : CPU-side bus, observed passively (adr, dat_r, dat_w, we, cyc,
//              stb, ack)
//   wb_*     : host register port used to configure and drain the tracer
//              (adr[2:0], dat_w, dat_r, we, cyc, stb, ack)
// Modports:
//   master : the side that drives the CPU bus and the host requests
//   slave  : the tracer, which only returns wb_dat_r / wb_ack
// -----------------------------------------------------------------------------
interface wb_snoop_tracer_if #(
   parameter int ADDR_W = 30,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0] snoop_adr;
   logic [DATA_W-1:0] snoop_dat_r;
   logic [DATA_W-1:0] snoop_dat_w;
   logic              snoop_we;
   logic              snoop_cyc;
   logic              snoop_stb;
   logic              snoop_ack;

   logic [2:0]        wb_adr;
   logic [31:0]       wb_dat_w;
   logic [31:0]       wb_dat_r;
   logic              wb_we;
   logic              wb_cyc;
   logic              wb_stb;
   logic              wb_ack;

   modport master (
      output snoop_adr, snoop_dat_r, snoop_dat_w, snoop_we,
             snoop_cyc, snoop_stb, snoop_ack,
      output wb_adr, wb_dat_w, wb_we, wb_cyc, wb_stb,
      input  wb_dat_r, wb_ack
   );

   modport slave (
      input  snoop_adr, snoop_dat_r, snoop_dat_w, snoop_we,
             snoop_cyc, snoop_stb, snoop_ack,
      input  wb_adr, wb_dat_w, wb_we, wb_cyc, wb_stb,
      output wb_dat_r, wb_ack
   );
endinterface

// File: rtl/wb_snoop_tracer.sv
// -----------------------------------------------------------------------------
// wb_snoop_tracer
// Passive trace buffer. Every completed CPU Wishbone transfer whose address
// passes the MASK/MATCH filter is stored as {we, adr, data} in a DEPTH-entry
// circular buffer; the host drains it through a small register file.
//
// Ports:
//   clk       : system clock
//   reset     : synchronous, active-high
//   bus       : wb_snoop_tracer_if.slave (snooped CPU bus + host register port)
//   overflow  : sticky overflow flag (same as STATUS[16])
//
// Host registers (word address):
//   0 CTRL      RW  [0] enable, [1] stop_on_full, [2] clear (pulse, reads 0)
//   1 STATUS    RO  [LVL_W-1:0] level, [16] overflow, [17] empty
//   2 MATCH     RW  [ADDR_W-1:0]
//   3 MASK      RW  [ADDR_W-1:0]
//   4 ENTRY_ADR RO  [31] we, [ADDR_W-1:0] adr of oldest entry
//   5 ENTRY_DAT RO  data of oldest entry, reading pops it
//   6,7             read 0, writes ignored
// -----------------------------------------------------------------------------
module wb_snoop_tracer #(
   parameter int ADDR_W = 30,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 16,
   parameter int LVL_W  = 11
) (
   input  logic             clk,
   input  logic             reset,
   wb_snoop_tracer_if.slave bus,
   output logic             overflow
);
   localparam int               PTR_W    = $clog2(DEPTH);
   localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);

   logic              enable;
   logic              stop_on_full;
   logic [ADDR_W-1:0] match;
   logic [ADDR_W-1:0] mask;
   logic [PTR_W-1:0]  wptr;
   logic [PTR_W-1:0]  rptr;
   logic [LVL_W-1:0]  level;

   logic              ent_we  [DEPTH];
   logic [ADDR_W-1:0] ent_adr [DEPTH];
   logic [DATA_W-1:0] ent_dat [DEPTH];

   logic              host_req;
   logic              host_acc;
   logic              host_wr;
   logic              host_rd;
   logic              full;
   logic              empty;
   logic              cap;
   logic              pop;
   logic              clr;
   logic              store;
   logic [31:0]       rd_data;
   logic              unused_dat_w;

   // Only some host write-data bits land in a register.
   assign unused_dat_w = ^bus.wb_dat_w;

   // A request is sampled only while ack is low, which forces an idle cycle
   // between acks. The register side effects happen in the ack cycle.
   assign host_req = bus.wb_cyc & bus.wb_stb & ~bus.wb_ack;
   assign host_acc = bus.wb_cyc & bus.wb_stb &  bus.wb_ack;
   assign host_wr  = host_acc &  bus.wb_we;
   assign host_rd  = host_acc & ~bus.wb_we;

   assign full  = (level == FULL_LVL);
   assign empty = (level == '0);

   assign cap = bus.snoop_cyc & bus.snoop_stb & bus.snoop_ack & enable &
                ((bus.snoop_adr & mask) == (match & mask));
   assign pop = host_rd & (bus.wb_adr == 3'd5) & ~empty;
   assign clr = host_wr & (bus.wb_adr == 3'd0) & bus.wb_dat_w[2];

   // A full buffer still accepts the entry if a pop frees the slot this cycle
   // or if overwrite mode is selected; clear discards the capture.
   assign store = cap & ~clr & (~full | pop | ~stop_on_full);

   always_comb begin
      rd_data = '0;
      case (bus.wb_adr)
         3'd0: rd_data[1:0] = {stop_on_full, enable};
         3'd1: begin
            rd_data[LVL_W-1:0] = level;
            rd_data[16]        = overflow;
            rd_data[17]        = empty;
         end
         3'd2: rd_data[ADDR_W-1:0] = match;
         3'd3: rd_data[ADDR_W-1:0] = mask;
         3'd4: if (!empty) begin
            rd_data[31]         = ent_we[rptr];
            rd_data[ADDR_W-1:0] = ent_adr[rptr];
         end
         3'd5: if (!empty) rd_data[DATA_W-1:0] = ent_dat[rptr];
         default: ;
      endcase
   end

   // Request stage -> ack stage: read data is latched with the ack.
   always_ff @(posedge clk) begin
      if (reset) begin
         bus.wb_ack   <= 1'b0;
         bus.wb_dat_r <= '0;
      end else begin
         bus.wb_ack   <= host_req;
         bus.wb_dat_r <= host_req ? rd_data : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         enable       <= 1'b0;
         stop_on_full <= 1'b0;
         match        <= '0;
         mask         <= '0;
      end else if (host_wr) begin
         case (bus.wb_adr)
            3'd0: begin
               enable       <= bus.wb_dat_w[0];
               stop_on_full <= bus.wb_dat_w[1];
            end
            3'd2: match <= bus.wb_dat_w[ADDR_W-1:0];
            3'd3: mask  <= bus.wb_dat_w[ADDR_W-1:0];
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wptr     <= '0;
         rptr     <= '0;
         level    <= '0;
         overflow <= 1'b0;
      end else if (clr) begin
         wptr     <= '0;
         rptr     <= '0;
         level    <= '0;
         overflow <= 1'b0;
      end else if (cap && pop) begin
         wptr <= wptr + PTR_ONE;
         rptr <= rptr + PTR_ONE;
      end else if (cap) begin
         if (!full) begin
            wptr  <= wptr + PTR_ONE;
            level <= level + LVL_ONE;
         end else begin
            overflow <= 1'b1;
            if (!stop_on_full) begin
               wptr <= wptr + PTR_ONE;
               rptr <= rptr + PTR_ONE;
            end
         end
      end else if (pop) begin
         rptr  <= rptr + PTR_ONE;
         level <= level - LVL_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (store) begin
         ent_we[wptr]  <= bus.snoop_we;
         ent_adr[wptr] <= bus.snoop_adr;
         ent_dat[wptr] <= bus.snoop_we ? bus.snoop_dat_w : bus.snoop_dat_r;
      end
   end
endmodule
